// File: rtl/controlador_lsu.sv
// rtl/controlador_lsu.sv - load/store unit bridging processor byte accesses to a word-wide RAM
// Sub-word stores do a read-modify-write; misaligned or malformed requests are rejected without touching RAM.
module controlador_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  tam,
  input  logic        signo,
  input  logic [31:0] direccion,
  input  logic [31:0] dato_e,
  output logic [31:0] dato_s,
  output logic        ocupado,
  output logic        listo,
  output logic        error_alin,
  output logic        ram_we,
  output logic [31:0] ram_dir,
  output logic [31:0] ram_dato_e,
  input  logic [31:0] ram_dato_s
);

  typedef enum logic [1:0] {INACTIVO, LEER, ESCRIBIR, FIN} estado_t;

  estado_t     estado, siguiente;
  logic [31:0] dir_r, dato_r, palabra_r;
  logic [1:0]  tam_r;
  logic        signo_r, lee_r, err_r;
  logic        rechazo;
  logic [4:0]  desplaz;
  logic [31:0] carril, extendido, mascara, fusion;

  always_comb begin
    rechazo = (tam == 2'b11) || (MemRead == MemWrite) ||
              (tam == 2'b01 && direccion[0]) ||
              (tam == 2'b10 && direccion[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= INACTIVO;
    else        estado <= siguiente;
  end

  always_comb begin
    siguiente  = estado;
    ocupado    = (estado != INACTIVO);
    listo      = (estado == FIN);
    error_alin = (estado == FIN) && err_r;
    ram_we     = (estado == ESCRIBIR);
    case (estado)
      INACTIVO: begin
        if (req) begin
          if (rechazo)           siguiente = FIN;
          else if (MemRead)      siguiente = LEER;
          else if (tam == 2'b10) siguiente = ESCRIBIR;
          else                   siguiente = LEER;
        end
      end
      LEER:     siguiente = lee_r ? FIN : ESCRIBIR;
      ESCRIBIR: siguiente = FIN;
      FIN:      siguiente = INACTIVO;
      default:  siguiente = INACTIVO;
    endcase
  end

  // Lane position in the word: little-endian, offset selects bits [8*off +: width].
  always_comb begin
    desplaz = {dir_r[1:0], 3'b000};
    carril  = ram_dato_s >> desplaz;
    case (tam_r)
      2'b00:   extendido = signo_r ? {{24{carril[7]}}, carril[7:0]} : {24'b0, carril[7:0]};
      2'b01:   extendido = signo_r ? {{16{carril[15]}}, carril[15:0]} : {16'b0, carril[15:0]};
      default: extendido = ram_dato_s;
    endcase
    mascara    = ((tam_r == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << desplaz;
    fusion     = (palabra_r & ~mascara) | ((dato_r << desplaz) & mascara);
    ram_dato_e = (tam_r == 2'b10) ? dato_r : fusion;
    ram_dir    = {dir_r[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r     <= '0;
      dato_r    <= '0;
      palabra_r <= '0;
      tam_r     <= '0;
      signo_r   <= 1'b0;
      lee_r     <= 1'b0;
      err_r     <= 1'b0;
      dato_s    <= '0;
    end else begin
      if (estado == INACTIVO && req) begin
        dir_r   <= direccion;
        dato_r  <= dato_e;
        tam_r   <= tam;
        signo_r <= signo;
        lee_r   <= MemRead;
        err_r   <= rechazo;
      end
      if (estado == LEER) begin
        palabra_r <= ram_dato_s;
        if (lee_r) dato_s <= extendido;
      end
    end
  end

endmodule

// File: tb/tb_controlador_lsu.sv
// tb/tb_controlador_lsu.sv - randomized self-checking bench for controlador_lsu
// Expected results come from a byte-level memory model kept in ref_mem.
module tb_controlador_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, signo = 1'b0;
  logic [1:0]  tam = 2'b00;
  logic [31:0] direccion = '0, dato_e = '0;
  logic [31:0] dato_s, ram_dir, ram_dato_e, ram_dato_s;
  logic        ocupado, listo, error_alin, ram_we;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] exp_dato = '0;
  int          errors = 0, checks = 0;

  controlador_lsu dut (
    .clk(clk), .rst_n(rst_n), .req(req), .MemRead(MemRead), .MemWrite(MemWrite),
    .tam(tam), .signo(signo), .direccion(direccion), .dato_e(dato_e),
    .dato_s(dato_s), .ocupado(ocupado), .listo(listo), .error_alin(error_alin),
    .ram_we(ram_we), .ram_dir(ram_dir), .ram_dato_e(ram_dato_e), .ram_dato_s(ram_dato_s)
  );

  always #5 clk = ~clk;

  assign ram_dato_s = mem[ram_dir[9:2]];
  always @(posedge clk) begin
    if (ram_we)      mem[ram_dir[9:2]] <= ram_dato_e;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [1:0] t, input logic s);
    logic [31:0] v;
    int bits;
    bits = (t == 2'b00) ? 8 : (t == 2'b01) ? 16 : 32;
    v = w / (32'd1 << (8 * off));
    if (bits < 32) begin
      v = v % (32'd1 << bits);
      if (s && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int off, input logic [1:0] t, input logic [31:0] d);
    logic [7:0] b [4];
    int n;
    n = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    for (int i = 0; i < n; i++) b[off + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] t, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    logic       rej, done, got_err;
    int         off, bytes, exp_lat, exp_we, lat, we_n;
    logic [7:0] idx;
    idx   = a[9:2];
    off   = a % 4;
    bytes = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    rej   = (t == 2'b11) || (rd == wr) || (off % bytes != 0);
    exp_we = 0;
    if (rej) exp_lat = 1;
    else if (rd) begin
      exp_lat  = 2;
      exp_dato = ref_load(ref_mem[idx], off, t, s);
    end else begin
      exp_lat = (bytes == 4) ? 2 : 3;
      exp_we  = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], off, t, d);
    end
    @(negedge clk);
    req = 1'b1; MemRead = rd; MemWrite = wr; tam = t; signo = s; direccion = a; dato_e = d;
    @(posedge clk);
    #1;
    req = 1'b0; direccion = $urandom; dato_e = $urandom; tam = 2'($urandom); signo = 1'($urandom);
    lat = 0; we_n = 0; done = 1'b0; got_err = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("ocupado_activo", ocupado, 1);
      if (ram_we) begin
        we_n++;
        check("ram_dir", ram_dir, a & 32'hFFFF_FFFC);
      end
      if (listo) begin
        done = 1'b1;
        got_err = error_alin;
      end
    end
    check("latencia", done ? lat : 99, exp_lat);
    check("ram_we_ciclos", we_n, exp_we);
    check("error_alin", got_err, rej);
    @(negedge clk);
    check("ocupado_libre", ocupado, 0);
    check("listo_pulso", listo, 0);
    check("dato_s", dato_s, exp_dato);
    check("ram_palabra", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    @(negedge clk);
    check("rst_dato_s", dato_s, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_listo", listo, 0);
    check("rst_error_alin", error_alin, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_dir", ram_dir, 0);
    rst_n = 1'b1;

    preload(8'h10, 32'h80FF7F01);
    do_op(1, 0, 2'b00, 1, 32'h41, 0);  check("lb_41", dato_s, 32'h0000007F);
    do_op(1, 0, 2'b00, 1, 32'h42, 0);  check("lb_42", dato_s, 32'hFFFFFFFF);
    do_op(1, 0, 2'b00, 0, 32'h43, 0);  check("lbu_43", dato_s, 32'h00000080);
    do_op(1, 0, 2'b01, 1, 32'h42, 0);  check("lh_42", dato_s, 32'hFFFF80FF);
    do_op(1, 0, 2'b01, 0, 32'h40, 0);  check("lhu_40", dato_s, 32'h00007F01);
    preload(8'h10, 32'h11223344);
    do_op(0, 1, 2'b00, 0, 32'h42, 32'h5A5A00AB);  check("sb_42", mem[8'h10], 32'h11AB3344);
    do_op(0, 1, 2'b10, 0, 32'h44, 32'hDEADBEEF);  check("sw_44", mem[8'h11], 32'hDEADBEEF);
    do_op(1, 0, 2'b10, 0, 32'h46, 0);  check("lw_46_dato", dato_s, 32'h00007F01);
    do_op(0, 1, 2'b01, 0, 32'h43, 32'hFFFF);
    do_op(1, 1, 2'b00, 0, 32'h40, 0);
    do_op(0, 0, 2'b10, 0, 32'h40, 0);
    do_op(1, 0, 2'b11, 0, 32'h40, 0);

    // Abort a sub-word store while it is reading the target word.
    @(negedge clk);
    req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; tam = 2'b00; direccion = 32'h82; dato_e = 32'hCC;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("abort_en_leer", ocupado, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ocupado", ocupado, 0);
    check("abort_ram_we", ram_we, 0);
    check("abort_dato_s", dato_s, 0);
    exp_dato = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_listo", listo, 0);
      check("abort_we", ram_we, 0);
    end
    check("abort_palabra", mem[8'h20], ref_mem[8'h20]);
    rst_n = 1'b1;
    do_op(1, 0, 2'b10, 0, 32'h80, 0);

    for (int n = 0; n < 60; n++) begin
      logic        rd, wr;
      logic [1:0]  t;
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin rd = 1'($urandom); wr = rd; end
      else begin rd = (sel < 5); wr = !rd; end
      t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (t == 2'b10) ? 2'b00 : (t == 2'b01) ? {a[1], 1'b0} : a[1:0];
      if ($urandom_range(0, 1) == 0) a[9:2] = 8'h10 + 8'($urandom_range(0, 3));
      do_op(rd, wr, t, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < 256; i++) check("ram_final", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
